pwm_capture: RTL



---
 rtl/pwm_capture.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of three PWM inputs
// (main, roll, pitch) and exposes them as 32-bit cycle counts on the
// 16-bit host register bus.
//
// Optional build macro PWM_CAP_FILTER_EN adds a per-channel glitch
// filter between the synchronizer and the edge detector. Without it,
// every synchronized edge is accepted.
//
// Register map (host_addr[4:0]):
//   ch*8 + 0/2/4/6 : WIDTH_LO / WIDTH_HI / PERIOD_LO / PERIOD_HI
//   0x18 STATUS    : [2:0] valid, [6:4] new, [10:8] timeout (read clears new/timeout)
//   0x1A CTRL      : [2:0] channel enable (reset 3'b111)

// One measurement channel: sync, optional filter, edge detect, FSM, counters.
module pwm_capture_chan #(
  parameter int unsigned TIMEOUT_CYC = 2400000,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic        host_clk,
  input  logic        host_rst,
  input  logic        en,
  input  logic        pin,
  output logic [31:0] width,
  output logic [31:0] period,
  output logic        valid,
  output logic        pub,
  output logic        tmo
);
  typedef enum logic [1:0] {IDLE, FIRST_HIGH, LOW, HIGH} state_t;

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYC);

  state_t      state, state_nxt;
  logic [1:0]  sync;
  logic        lvl, lvl_d, rise, fall;
  logic [31:0] cnt, width_pend;
  logic        sat, cnt_one, cap_pend, clr;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge host_clk) begin
    if (host_rst) sync <= '0;
    else          sync <= {sync[0], pin};
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  logic [FW-1:0] flt_cnt;

  // Follow the synchronized level only once it has disagreed for FILTER_LEN cycles.
  always_ff @(posedge host_clk) begin
    if (host_rst) begin
      lvl     <= 1'b0;
      flt_cnt <= '0;
    end else if (sync[1] == lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_LAST) begin
      lvl     <= sync[1];
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end
`else
  localparam int unsigned FILTER_LEN_UNUSED = FILTER_LEN;
  assign lvl = sync[1];
`endif

  // Delayed level for edge detection; both edges see the same latency.
  always_ff @(posedge host_clk) begin
    if (host_rst) lvl_d <= 1'b0;
    else          lvl_d <= lvl;
  end

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;
  assign sat  = (cnt == TMO);

  // FSM state register.
  always_ff @(posedge host_clk) begin
    if (host_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and datapath strobes; disable beats any edge, edges beat timeout.
  always_comb begin
    state_nxt = state;
    cnt_one   = 1'b0;
    cap_pend  = 1'b0;
    pub       = 1'b0;
    tmo       = 1'b0;
    clr       = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      clr       = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = FIRST_HIGH;
            cnt_one   = 1'b1;
          end
        end
        FIRST_HIGH, HIGH: begin
          if (fall) begin
            cap_pend  = 1'b1;
            state_nxt = LOW;
          end else if (sat) begin
            state_nxt = IDLE;
            clr       = 1'b1;
            tmo       = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            pub       = 1'b1;
            cnt_one   = 1'b1;
            state_nxt = HIGH;
          end else if (sat) begin
            state_nxt = IDLE;
            clr       = 1'b1;
            tmo       = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Cycle counter: restarts at 1 on an accepted rise, saturates at the timeout.
  always_ff @(posedge host_clk) begin
    if (host_rst)                      cnt <= '0;
    else if (cnt_one)                  cnt <= 32'd1;
    else if (state != IDLE && !sat)    cnt <= cnt + 32'd1;
  end

  // Measurement registers; width is held pending until the period closes.
  always_ff @(posedge host_clk) begin
    if (host_rst) begin
      width      <= '0;
      period     <= '0;
      width_pend <= '0;
      valid      <= 1'b0;
    end else begin
      if (cap_pend) width_pend <= cnt;
      if (clr) begin
        width  <= '0;
        period <= '0;
        valid  <= 1'b0;
      end else if (pub) begin
        width  <= width_pend;
        period <= cnt;
        valid  <= 1'b1;
      end
    end
  end
endmodule

// Top: three channels plus the host register interface.
module pwm_capture #(
  parameter int unsigned TIMEOUT_CYC = 2400000,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic        host_clk,
  input  logic        host_rst,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wr_data,
  input  logic        host_cs,
  input  logic        host_rd_en,
  input  logic        host_wr_en,
  output logic [15:0] host_rd_data,
  input  logic [2:0]  pwm_in
);
  localparam int NUM_CH = 3;

  logic [NUM_CH-1:0][31:0] width, period;
  logic [NUM_CH-1:0][15:0] wshd, pshd;
  logic [NUM_CH-1:0]       valid, pub, tmo, new_f, tmo_f, ctrl;
  logic [NUM_CH-1:0]       ld_wshd, ld_pshd;
  logic [15:0]             rd_mux, status;
  logic                    rd, wr, clr_st;
  logic                    unused_ok;

  assign rd        = host_cs & host_rd_en;
  assign wr        = host_cs & host_wr_en;
  assign status    = {5'b0, tmo_f, 1'b0, new_f, 1'b0, valid};
  assign unused_ok = &{1'b0, host_addr[15:5], host_wr_data[15:3]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_capture_chan #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .FILTER_LEN  (FILTER_LEN)
    ) u_chan (
      .host_clk (host_clk),
      .host_rst (host_rst),
      .en       (ctrl[c]),
      .pin      (pwm_in[c]),
      .width    (width[c]),
      .period   (period[c]),
      .valid    (valid[c]),
      .pub      (pub[c]),
      .tmo      (tmo[c])
    );
  end

  // Address decode: read mux, shadow-load selects and STATUS clear strobe.
  always_comb begin
    rd_mux  = '0;
    ld_wshd = '0;
    ld_pshd = '0;
    clr_st  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (host_addr[4:3] == 2'(c)) begin
        case (host_addr[2:0])
          3'd0: begin rd_mux = width[c][15:0];  ld_wshd[c] = 1'b1; end
          3'd2: rd_mux = wshd[c];
          3'd4: begin rd_mux = period[c][15:0]; ld_pshd[c] = 1'b1; end
          3'd6: rd_mux = pshd[c];
          default: ;
        endcase
      end
    end
    if (host_addr[4:0] == 5'h18) begin
      rd_mux = status;
      clr_st = rd;
    end
    if (host_addr[4:0] == 5'h1A) rd_mux = {13'b0, ctrl};
  end

  // Registered read data, held between reads.
  always_ff @(posedge host_clk) begin
    if (host_rst) host_rd_data <= '0;
    else if (rd)  host_rd_data <= rd_mux;
  end

  // Hi-half shadows latched on the lo read so 32-bit reads stay coherent.
  always_ff @(posedge host_clk) begin
    if (host_rst) begin
      wshd <= '0;
      pshd <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd && ld_wshd[c]) wshd[c] <= width[c][31:16];
        if (rd && ld_pshd[c]) pshd[c] <= period[c][31:16];
      end
    end
  end

  // Sticky event flags; a new event in the clearing cycle survives.
  always_ff @(posedge host_clk) begin
    if (host_rst) begin
      new_f <= '0;
      tmo_f <= '0;
    end else begin
      new_f <= (new_f & ~{NUM_CH{clr_st}}) | pub;
      tmo_f <= (tmo_f & ~{NUM_CH{clr_st}}) | tmo;
    end
  end

  // Channel enable register.
  always_ff @(posedge host_clk) begin
    if (host_rst)                            ctrl <= 3'b111;
    else if (wr && host_addr[4:0] == 5'h1A)  ctrl <= host_wr_data[2:0];
  end
endmodule
